// File: rtl/tcs3200_pkg.sv
// Shared encodings for the TCS3200 filter/scale interface and the emulator FSM.
// The colour-detector FSM imports the same filter constants.
package tcs3200_pkg;

  // S2S3 filter select
  localparam logic [1:0] FILT_RED   = 2'd0;
  localparam logic [1:0] FILT_BLUE  = 2'd1;
  localparam logic [1:0] FILT_CLEAR = 2'd2;
  localparam logic [1:0] FILT_GREEN = 2'd3;

  // S0S1 frequency scale select
  localparam logic [1:0] SCALE_OFF    = 2'd0;
  localparam logic [1:0] SCALE_2PCT   = 2'd1;
  localparam logic [1:0] SCALE_20PCT  = 2'd2;
  localparam logic [1:0] SCALE_100PCT = 2'd3;

  // Period multipliers: a lower output scale means a longer period
  localparam int         MULT_W      = 6;
  localparam logic [5:0] MULT_2PCT   = 6'd50;
  localparam logic [5:0] MULT_20PCT  = 6'd5;
  localparam logic [5:0] MULT_100PCT = 6'd1;

  // Emulator FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_OFF    = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_HIGH   = 2'd2;
  localparam state_t ST_LOW    = 2'd3;

  function automatic logic [MULT_W-1:0] scale_mult(input logic [1:0] scale);
    logic [MULT_W-1:0] m;
    m = '0;
    case (scale)
      SCALE_2PCT:   m = MULT_2PCT;
      SCALE_20PCT:  m = MULT_20PCT;
      SCALE_100PCT: m = MULT_100PCT;
      default:      m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tcs3200_period_sel.sv
// Effective half-period H: selects the channel's base half-period and applies
// the scale multiplier at full width so the product never truncates.
module tcs3200_period_sel
  import tcs3200_pkg::*;
#(
  parameter int PERIOD_W = 8
) (
  input  logic [1:0]               filter,
  input  logic [1:0]               scale,
  input  logic [PERIOD_W-1:0]      red_half,
  input  logic [PERIOD_W-1:0]      green_half,
  input  logic [PERIOD_W-1:0]      blue_half,
  input  logic [PERIOD_W-1:0]      clear_half,
  output logic [PERIOD_W+MULT_W-1:0] half_period
);

  localparam int HW = PERIOD_W + MULT_W;

  logic [PERIOD_W-1:0] base;

  always_comb begin
    // NOTE: a default before the case keeps this block free of inferred latches.
    base = '0;
    case (filter)
      FILT_RED:   base = red_half;
      FILT_BLUE:  base = blue_half;
      FILT_CLEAR: base = clear_half;
      FILT_GREEN: base = green_half;
      default:    base = '0;
    endcase
  end

  assign half_period = HW'(base) * HW'(scale_mult(scale));

endmodule

// File: rtl/tcs3200_emulator.sv
// Behavioural TCS3200 responder: decodes filter/scale selects and drives a
// 50 % duty square wave on cs_out, with a settling dead time after each change.
module tcs3200_emulator
  import tcs3200_pkg::*;
#(
  parameter int PERIOD_W      = 8,
  parameter int SETTLE_CYCLES = 20
) (
  input  logic                clk_1MHz,
  input  logic                rst,
  input  logic [1:0]          filter,
  input  logic [1:0]          scale,
  input  logic [PERIOD_W-1:0] red_half,
  input  logic [PERIOD_W-1:0] green_half,
  input  logic [PERIOD_W-1:0] blue_half,
  input  logic [PERIOD_W-1:0] clear_half,
  output logic                cs_out,
  output logic                settling,
  output logic [15:0]         pulse_cnt
);

  localparam int                CNT_W       = PERIOD_W + MULT_W;
  localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ONE         = CNT_W'(1);

  state_t           state, state_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       scale_q, scale_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] h;

  // H follows the captured selects; half inputs are only consumed at phase boundaries
  tcs3200_period_sel #(.PERIOD_W(PERIOD_W)) u_period_sel (
    .filter      (filt_q),
    .scale       (scale_q),
    .red_half    (red_half),
    .green_half  (green_half),
    .blue_half   (blue_half),
    .clear_half  (clear_half),
    .half_period (h)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    filt_d  = filt_q;
    scale_d = scale_q;
    if (scale == SCALE_OFF) begin
      state_d = ST_OFF;
      scale_d = SCALE_OFF;
    end else if (state == ST_OFF || filter != filt_q || scale != scale_q) begin
      state_d = ST_SETTLE;
      filt_d  = filter;
      scale_d = scale;
      cnt_d   = SETTLE_INIT;
    end else begin
      case (state)
        ST_SETTLE, ST_LOW: begin
          if (cnt != '0) begin
            cnt_d = cnt - ONE;
          end else if (h != '0) begin
            state_d = ST_HIGH;
            cnt_d   = h - ONE;
          end else begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end
        end
        ST_HIGH: begin
          if (cnt != '0) begin
            cnt_d = cnt - ONE;
          end else begin
            state_d = ST_LOW;
            // H dropping to zero mid-stream parks in LOW instead of underflowing
            cnt_d   = (h != '0) ? h - ONE : '0;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state     <= ST_OFF;
      filt_q    <= FILT_RED;
      scale_q   <= SCALE_OFF;
      cnt       <= '0;
      cs_out    <= 1'b0;
      settling  <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_d;
      filt_q   <= filt_d;
      scale_q  <= scale_d;
      cnt      <= cnt_d;
      cs_out   <= (state_d == ST_HIGH);
      settling <= (state_d == ST_SETTLE);
      if (state_d == ST_HIGH && state != ST_HIGH)
        pulse_cnt <= pulse_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tcs3200_emulator.sv
// Directed bench for tcs3200_emulator: table of timed vectors plus hand-written
// sequences for mid-phase changes and asynchronous reset.
`timescale 1ns/1ps
module tb_tcs3200_emulator;
  import tcs3200_pkg::*;

  logic        clk_1MHz = 1'b0;
  logic        rst;
  logic [1:0]  filter, scale;
  logic [7:0]  red_half, green_half, blue_half, clear_half;
  logic        cs_out, settling;
  logic [15:0] pulse_cnt;

  always #500 clk_1MHz = ~clk_1MHz;

  tcs3200_emulator #(.PERIOD_W(8), .SETTLE_CYCLES(20)) dut (
    .clk_1MHz   (clk_1MHz),
    .rst        (rst),
    .filter     (filter),
    .scale      (scale),
    .red_half   (red_half),
    .green_half (green_half),
    .blue_half  (blue_half),
    .clear_half (clear_half),
    .cs_out     (cs_out),
    .settling   (settling),
    .pulse_cnt  (pulse_cnt)
  );

  typedef struct {
    logic [1:0]  filter;
    logic [1:0]  scale;
    logic [7:0]  red, green, blue, clear;
    int          cycles;
    logic        cs;
    logic        st;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_pc;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic cs, input logic st, input logic [15:0] pc);
    check({tag, " cs_out"},    {15'd0, cs_out},   {15'd0, cs});
    check({tag, " settling"},  {15'd0, settling}, {15'd0, st});
    check({tag, " pulse_cnt"}, pulse_cnt,         pc);
  endtask

  // Advance n active edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_1MHz);
    #1;
  endtask

  task automatic add(input logic [1:0] f, input logic [1:0] s,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [7:0] c,
                     input int cyc, input logic cs, input logic st, input logic [15:0] pc);
    vec_t v;
    v.filter = f; v.scale = s; v.red = r; v.green = g; v.blue = b; v.clear = c;
    v.cycles = cyc; v.cs = cs; v.st = st; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; filter = FILT_RED; scale = SCALE_OFF;
    red_half = 8'd10; green_half = 8'd10; blue_half = 8'd6; clear_half = 8'd0;

    // red, x1, H=10: 20-cycle settle then period 20
    add(0, 3, 10, 10, 6, 0,     1, 0, 1,  0);
    add(0, 3, 10, 10, 6, 0,    19, 0, 1,  0);
    add(0, 3, 10, 10, 6, 0,     1, 1, 0,  1);
    add(0, 3, 10, 10, 6, 0,     9, 1, 0,  1);
    add(0, 3, 10, 10, 6, 0,     1, 0, 0,  1);
    add(0, 3, 10, 10, 6, 0,     9, 0, 0,  1);
    add(0, 3, 10, 10, 6, 0,     1, 1, 0,  2);
    add(0, 3, 10, 10, 6, 0,    60, 1, 0,  5);
    // green, x5, H=50
    add(3, 2, 10, 10, 6, 0,     1, 0, 1,  5);
    add(3, 2, 10, 10, 6, 0,    20, 1, 0,  6);
    add(3, 2, 10, 10, 6, 0,    49, 1, 0,  6);
    add(3, 2, 10, 10, 6, 0,     1, 0, 0,  6);
    add(3, 2, 10, 10, 6, 0,    50, 1, 0,  7);
    // green, x50, H=500
    add(3, 1, 10, 10, 6, 0,     1, 0, 1,  7);
    add(3, 1, 10, 10, 6, 0,    20, 1, 0,  8);
    add(3, 1, 10, 10, 6, 0,   499, 1, 0,  8);
    add(3, 1, 10, 10, 6, 0,     1, 0, 0,  8);
    add(3, 1, 10, 10, 6, 0,   499, 0, 0,  8);
    add(3, 1, 10, 10, 6, 0,     1, 1, 0,  9);
    // clear with zero half-period: silent, then clear_half=4 starts within a cycle
    add(2, 3, 10, 10, 6, 0,     1, 0, 1,  9);
    add(2, 3, 10, 10, 6, 0,    20, 0, 0,  9);
    add(2, 3, 10, 10, 6, 0,    30, 0, 0,  9);
    add(2, 3, 10, 10, 6, 4,     1, 1, 0, 10);
    add(2, 3, 10, 10, 6, 4,     3, 1, 0, 10);
    add(2, 3, 10, 10, 6, 4,     1, 0, 0, 10);
    add(2, 3, 10, 10, 6, 4,     4, 1, 0, 11);
    // power-down, then a full settle on return
    add(2, 0, 10, 10, 6, 4,     1, 0, 0, 11);
    add(2, 0, 10, 10, 6, 4,     5, 0, 0, 11);
    add(2, 3, 10, 10, 6, 4,     1, 0, 1, 11);
    add(2, 3, 10, 10, 6, 4,    19, 0, 1, 11);
    add(2, 3, 10, 10, 6, 4,     1, 1, 0, 12);
    // largest half-period 255 x 50 = 12750
    add(0, 1, 255, 10, 6, 4,    1, 0, 1, 12);
    add(0, 1, 255, 10, 6, 4,   20, 1, 0, 13);
    add(0, 1, 255, 10, 6, 4, 12749, 1, 0, 13);
    add(0, 1, 255, 10, 6, 4,    1, 0, 0, 13);
    add(0, 1, 255, 10, 6, 4, 12749, 0, 0, 13);
    add(0, 1, 255, 10, 6, 4,    1, 1, 0, 14);

    #200;
    check_outs("reset", 1'b0, 1'b0, 16'd0);
    @(negedge clk_1MHz);
    rst = 1'b0;
    step(2);
    check_outs("off_after_reset", 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      filter = vecs[i].filter; scale = vecs[i].scale;
      red_half = vecs[i].red; green_half = vecs[i].green;
      blue_half = vecs[i].blue; clear_half = vecs[i].clear;
      step(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].cs, vecs[i].st, vecs[i].pc);
    end
    exp_pc = int'(vecs[vecs.size()-1].pc);

    // Filter red->blue three cycles into a HIGH phase
    filter = FILT_RED; scale = SCALE_100PCT;
    red_half = 8'd10; blue_half = 8'd6; clear_half = 8'd4;
    step(1);
    check_outs("midhigh_settle", 1'b0, 1'b1, 16'(exp_pc));
    step(20);
    exp_pc++;
    check_outs("midhigh_first_high", 1'b1, 1'b0, 16'(exp_pc));
    step(3);
    check_outs("midhigh_3in", 1'b1, 1'b0, 16'(exp_pc));
    filter = FILT_BLUE;
    step(1);
    check_outs("midhigh_cut", 1'b0, 1'b1, 16'(exp_pc));
    step(19);
    check_outs("midhigh_settle_end", 1'b0, 1'b1, 16'(exp_pc));
    step(1);
    exp_pc++;
    check_outs("blue_first_high", 1'b1, 1'b0, 16'(exp_pc));

    // blue_half changed mid-HIGH: current phase keeps H=6, LOW uses H=3
    step(2);
    blue_half = 8'd3;
    step(3);
    check_outs("blue_high_end", 1'b1, 1'b0, 16'(exp_pc));
    step(1);
    check_outs("blue_low_start", 1'b0, 1'b0, 16'(exp_pc));
    step(2);
    check_outs("blue_low_short", 1'b0, 1'b0, 16'(exp_pc));
    step(1);
    exp_pc++;
    check_outs("blue_high_again", 1'b1, 1'b0, 16'(exp_pc));

    // Asynchronous reset in the middle of a HIGH phase
    #200;
    rst = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 16'd0);
    @(negedge clk_1MHz);
    rst = 1'b0;
    step(1);
    check_outs("post_reset_settle", 1'b0, 1'b1, 16'd0);
    step(19);
    check_outs("post_reset_settle_end", 1'b0, 1'b1, 16'd0);
    step(1);
    check_outs("post_reset_high", 1'b1, 1'b0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
